// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU control
// bundle values, FSM states and the opcode classifier used by control and decode.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_I      = 2'b11;

  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_FOUR = 2'b10;

  localparam logic [1:0] SRC1_REG  = 2'b00;
  localparam logic [1:0] SRC1_ZERO = 2'b01;
  localparam logic [1:0] SRC1_PC   = 2'b10;

  localparam logic PCSRC_PPC = 1'b0;
  localparam logic PCSRC_REG = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t cls;
    case (opcode)
      OPC_R:      cls = CL_R;
      OPC_I:      cls = CL_I;
      OPC_LOAD:   cls = CL_LOAD;
      OPC_STORE:  cls = CL_STORE;
      OPC_BRANCH: cls = CL_BRANCH;
      OPC_LUI:    cls = CL_LUI;
      OPC_AUIPC:  cls = CL_AUIPC;
      OPC_JAL:    cls = CL_JAL;
      OPC_JALR:   cls = CL_JALR;
      default:    cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational ALU control bundle from the latched instruction fields and the
// current FSM state; the bundle is live in EXEC and held through MEM and WB.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] ir_funct3,
  input  logic [6:0] ir_funct7,
  input  state_t     state,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src,
  output logic [1:0] alu_src1,
  output logic       pc_src,
  output logic [2:0] funct3,
  output logic [6:0] funct7
);

  logic in_exec_phase;
  assign in_exec_phase = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

  always_comb begin
    alu_op   = ALUOP_ADD;
    alu_src  = SRC2_REG;
    alu_src1 = SRC1_REG;
    pc_src   = PCSRC_PPC;
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    if (in_exec_phase) begin
      case (classify(opcode))
        CL_R: begin
          alu_op = ALUOP_R;
          funct3 = ir_funct3;
          funct7 = ir_funct7;
        end
        CL_I: begin
          alu_op  = ALUOP_I;
          alu_src = SRC2_IMM;
          funct3  = ir_funct3;
          // only shifts carry a meaningful funct7 (SRLI vs SRAI)
          if (ir_funct3 == 3'b001 || ir_funct3 == 3'b101) funct7 = ir_funct7;
        end
        CL_LOAD, CL_STORE: begin
          alu_src = SRC2_IMM;
        end
        CL_BRANCH: begin
          alu_op = ALUOP_BRANCH;
          funct3 = ir_funct3;
        end
        CL_LUI: begin
          alu_src1 = SRC1_ZERO;
          alu_src  = SRC2_IMM;
        end
        CL_AUIPC: begin
          alu_src1 = SRC1_PC;
          alu_src  = SRC2_IMM;
        end
        CL_JAL: begin
          alu_src1 = SRC1_PC;
          alu_src  = SRC2_FOUR;
        end
        CL_JALR: begin
          alu_src1 = SRC1_PC;
          alu_src  = SRC2_FOUR;
          pc_src   = PCSRC_REG;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with
// memory handshakes, sticky illegal-opcode halt and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int REGWIDTH   = 32,
  parameter int ALUOPWIDTH = 2,
  parameter int CNTWIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REGWIDTH-1:0]   instr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  input  logic                  zero,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  npc_sel,
  output logic [ALUOPWIDTH-1:0] ALUOp,
  output logic [1:0]            ALUSrc,
  output logic [1:0]            ALUSrc1,
  output logic                  PCSrc,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic                  RegWrite,
  output logic                  MemtoReg,
  output logic                  illegal,
  output logic [CNTWIDTH-1:0]   instret
);

  state_t              state_reg, state_next;
  logic                active_reg;
  logic [6:0]          opcode_reg;
  logic [2:0]          f3_reg;
  logic [6:0]          f7_reg;
  logic                illegal_reg;
  logic [CNTWIDTH-1:0] instret_reg;
  logic                retire;
  logic                illegal_set;
  op_class_t           op_class;
  logic [1:0]          alu_op;
  logic                unused_instr;

  assign unused_instr = ^instr;
  assign op_class     = classify(opcode_reg);

  // active_reg keeps every output low for the cycle right after reset and
  // makes an ack arriving on the reset edge harmless
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH;
      active_reg  <= 1'b0;
      opcode_reg  <= '0;
      f3_reg      <= '0;
      f7_reg      <= '0;
      illegal_reg <= 1'b0;
      instret_reg <= '0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
      if (ir_write) begin
        opcode_reg <= instr[6:0];
        f3_reg     <= instr[14:12];
        f7_reg     <= instr[31:25];
      end
      if (illegal_set) illegal_reg <= 1'b1;
      if (retire) instret_reg <= instret_reg + 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_write    = 1'b0;
    npc_sel     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    retire      = 1'b0;
    illegal_set = 1'b0;
    if (active_reg) begin
      case (state_reg)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write   = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op_class == CL_ILLEGAL) begin
            illegal_set = 1'b1;
            state_next  = ST_HALT;
          end else begin
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_class)
            CL_BRANCH: begin
              pc_write   = 1'b1;
              npc_sel    = zero;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
            CL_LOAD, CL_STORE: state_next = ST_MEM;
            default:           state_next = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (op_class == CL_STORE);
          if (dmem_ack) begin
            if (op_class == CL_STORE) begin
              pc_write   = 1'b1;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end else begin
              state_next = ST_WB;
            end
          end
        end
        ST_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = (op_class == CL_LOAD);
          pc_write   = 1'b1;
          npc_sel    = (op_class == CL_JAL) || (op_class == CL_JALR);
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_FETCH;
      endcase
    end
  end

  ctrl_decode u_decode (
    .opcode    (opcode_reg),
    .ir_funct3 (f3_reg),
    .ir_funct7 (f7_reg),
    .state     (state_reg),
    .alu_op    (alu_op),
    .alu_src   (ALUSrc),
    .alu_src1  (ALUSrc1),
    .pc_src    (PCSrc),
    .funct3    (funct3),
    .funct7    (funct7)
  );

  assign ALUOp   = ALUOPWIDTH'(alu_op);
  assign illegal = illegal_reg;
  assign instret = instret_reg;

endmodule
